// File: rtl/per_sequencer.sv
// Training sequencer for the perceptron core: per sample GAP -> LOAD -> RUN, walking
// NUM_SAMPLES addresses for NUM_EPOCHS epochs. Optional stall input under PER_SEQ_PAUSE_EN.
module per_sequencer #(
  parameter int         ADDR_W      = 11,
  parameter int         NUM_SAMPLES = 501,
  parameter int         LOAD_CYCLES = 5,
  parameter int         RUN_CYCLES  = 30,
  parameter int         NUM_EPOCHS  = 1,
  parameter logic [3:0] CTRL_RUN    = 4'b1111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef PER_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic              core_rst,
  output logic [3:0]        core_control,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [7:0]        epoch,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int PH_MAX = (LOAD_CYCLES > RUN_CYCLES) ? LOAD_CYCLES : RUN_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic              r_core_rst;
  logic [3:0]        r_core_control;
  logic [ADDR_W-1:0] r_sample_addr;
  logic [7:0]        r_epoch;
  logic              r_busy;
  logic              r_done;
  logic              w_stall;

`ifdef PER_SEQ_PAUSE_EN
  assign w_stall = pause;
`else
  assign w_stall = 1'b0;
`endif

  // Outputs are updated on the same edge as the state, so they always describe the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_phase        <= '0;
      r_core_rst     <= 1'b0;
      r_core_control <= 4'd0;
      r_sample_addr  <= '0;
      r_epoch        <= 8'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_GAP;
            r_phase       <= '0;
            r_sample_addr <= '0;
            r_epoch       <= 8'd0;
            r_busy        <= 1'b1;
          end
        end
        S_GAP: begin
          if (!w_stall) begin
            r_state    <= S_LOAD;
            r_phase    <= '0;
            r_core_rst <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!w_stall) begin
            if (r_phase == PH_W'(LOAD_CYCLES - 1)) begin
              r_state        <= S_RUN;
              r_phase        <= '0;
              r_core_rst     <= 1'b0;
              r_core_control <= CTRL_RUN;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!w_stall) begin
            if (r_phase == PH_W'(RUN_CYCLES - 1)) begin
              r_phase        <= '0;
              r_core_control <= 4'd0;
              // Address only returns to 0 through the epoch wrap, never by counter overflow.
              if (r_sample_addr < ADDR_W'(NUM_SAMPLES - 1)) begin
                r_sample_addr <= r_sample_addr + 1'b1;
                r_state       <= S_GAP;
              end else if (r_epoch < 8'(NUM_EPOCHS - 1)) begin
                r_sample_addr <= '0;
                r_epoch       <= r_epoch + 8'd1;
                r_state       <= S_GAP;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_phase <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_phase <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst     = r_core_rst;
  assign core_control = r_core_control;
  assign sample_addr  = r_sample_addr;
  assign epoch        = r_epoch;
  assign busy         = r_busy;
  assign done         = r_done;
  assign dbg_state    = r_state;

endmodule

// File: doc/per_sequencer.md
Name: per_sequencer

Overview:
- Hardware training sequencer for the perceptron core. It produces the per-sample core reset/control waveform and the shared sample address.
- Replaces bench-driven stimulus. It walks samples 0..NUM_SAMPLES-1 of the x1/x2/label memories for NUM_EPOCHS epochs.
- Sits beside the core. core_rst and core_control drive the core. sample_addr drives the x1, x2 and label memory addresses in common.

Parameters:
ADDR_W, 11, sample address width (x1/x2/label memories)
NUM_SAMPLES, 501, samples per epoch (1..2^ADDR_W)
LOAD_CYCLES, 5, cycles core_rst is held high per sample (>=1)
RUN_CYCLES, 30, cycles core_control is held at CTRL_RUN per sample (>=1)
NUM_EPOCHS, 1, passes over the data set (1..255)
CTRL_RUN, 4'b1111, core control word during the run phase

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  1-cycle request to begin training; ignored unless state is IDLE
core_rst  out  1  reset/load strobe to the core, active-high
core_control  out  4  control word to the core
sample_addr  out  ADDR_W  shared x1/x2/label memory address
epoch  out  8  current epoch index, 0-based
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse after the final sample's run phase

Behaviour:
- Reset (rst=0, async): state=IDLE; core_rst=0, core_control=0, sample_addr=0, epoch=0, busy=0, done=0. Reset asserted mid-operation aborts immediately. No done pulse is produced.
- All outputs are registered. No combinational path from start to any output.
- IDLE: outputs idle. start=1 -> GAP; sample_addr<=0, epoch<=0.
- GAP (1 cycle): core_rst=0, core_control=0 -> LOAD.
- LOAD (LOAD_CYCLES cycles): core_rst=1, core_control=0. sample_addr is stable throughout. Last cycle -> RUN.
- RUN (RUN_CYCLES cycles): core_rst=0, core_control=CTRL_RUN. On the last cycle:
  - sample_addr<NUM_SAMPLES-1: sample_addr+1, -> GAP.
  - else if epoch<NUM_EPOCHS-1: sample_addr<=0, epoch+1, -> GAP.
  - else -> DONE.
- DONE (1 cycle): done=1, busy=1, core_control=0, core_rst=0 -> IDLE. sample_addr and epoch hold their final values until the next start.
- Per-sample period: exactly 1+LOAD_CYCLES+RUN_CYCLES cycles (36 at defaults). Total run: NUM_SAMPLES*NUM_EPOCHS*period + 1 cycles from the first GAP to DONE inclusive.
- Phase counter: width clog2(max(LOAD_CYCLES,RUN_CYCLES))+1. Cleared on every state change.
- Address never exceeds NUM_SAMPLES-1. With NUM_SAMPLES=2^ADDR_W the last address is all-ones. Reset to 0 happens only via the epoch-wrap branch, never by overflow.
- start while busy: ignored. No queuing.
- start in the same cycle as the DONE pulse: ignored, because state is DONE, not IDLE.

Optional Feature:
- Macro PER_SEQ_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 the state and phase counter freeze in every state except IDLE and DONE. Outputs hold their current values; in LOAD core_rst stays 1. Pause does not delay the DONE pulse. pause in IDLE has no effect.
- Undefined: port absent; sequencing is never stalled.

Test Plan:
- Reset: drive rst=0 at an arbitrary mid-RUN cycle -> all outputs 0 in the same cycle, before the next clk edge. After release, state is IDLE and start is required.
- Single epoch, NUM_SAMPLES=3, LOAD=5, RUN=30, start at cycle 0:
  - sample_addr = 0, 1, 2 in turn. core_rst high for 5 cycles per sample, control=4'hF for 30 cycles per sample.
  - done pulses at cycle 109 (3*36+1), then busy=0.
- Two epochs (NUM_EPOCHS=2, NUM_SAMPLES=3): after sample 2 of epoch 0, epoch becomes 1 and sample_addr returns to 0. Exactly 6 LOAD phases occur; a single done pulse follows.
- Boundary: ADDR_W=2, NUM_SAMPLES=4 -> addresses 0, 1, 2, 3 with no wrap to 0 before DONE; sample_addr holds 3 after done.
- start pulsed during LOAD and in the DONE cycle -> no restart, no change to the period; the next start, issued from IDLE, restarts at address 0, epoch 0.
- PER_SEQ_PAUSE_EN: pause=1 for 10 cycles mid-LOAD -> core_rst stays high for 15 cycles total. Done is delayed by exactly 10 cycles versus the unpaused run.
